mem_access: RTL
===============

# mem_access

Memory-access (MEM) stage of the 16-bit pipeline, between the EX/MEM register and `mem_wb`. It passes ALU results straight through for non-memory instructions. Loads and stores run on the shared data bus through a req/ack handshake, and the UART status word is decoded locally without a bus cycle. While a bus access is in flight the block stalls everything upstream and presents a bubble to `mem_wb`.

## Interface
- `BUS_TIMEOUT`, default 255: ACCESS-state cycles without ack before the access is abandoned (1..255).
- `mwi_clk  in  1`: clock; all state updates on the rising edge.
- `mwi_rst  in  1`: reset, asynchronous, active-low.
- `mi_instr, mi_pc  in  16 each`: instruction and PC from EX/MEM.
- `mi_alu_result  in  16`: ALU result; this is the address for loads and stores.
- `mi_store_data  in  16`: store data.
- `mi_mem_rd, mi_mem_wr  in  1 each`: load / store request.
- `mi_wreg_addr  in  4`, `mi_reg_wrn  in  1`: writeback destination and write enable.
- `mi_uart_tbre, mi_uart_tsre, mi_uart_data_ready  in  1 each`: UART status lines.
- `mo_bus_req, mo_bus_we  out  1 each`: registered bus request and write strobe.
- `mo_bus_addr, mo_bus_wdata  out  16 each`: registered bus address and write data.
- `mi_bus_rdata  in  16`, `mi_bus_ack  in  1`: bus read data and completion.
- `mo_instr, mo_pc, mo_result  out  16 each`: to `mem_wb`.
- `mo_wreg_addr  out  4`, `mo_reg_wrn  out  1`: to `mem_wb`.
- `mo_valid  out  1`: drives `mem_wb` enable. Low means `mem_wb` loads a bubble.
- `mo_stall  out  1`: freezes PC, IF/ID, ID/EX and EX/MEM.
- `mo_bus_err  out  1`: sticky; set on timeout, cleared only by reset.

## Operation
- FSM states: IDLE, ACCESS, DONE. Encodings live in `defines.v`.
- Bus-op condition: `(mi_mem_rd | mi_mem_wr)`, excluding a read of `UART_STAT` (16'hBF01).
- IDLE, no bus-op:
  - Combinational pass-through, `mo_valid=1`, `mo_stall=0`.
  - `mo_result = mi_alu_result`, except a read of `UART_STAT` returns `{14'b0, mi_uart_data_ready, mi_uart_tbre & mi_uart_tsre}`.
- IDLE, bus-op:
  - `mo_stall=1`, `mo_valid=0`.
  - On the edge: latch addr, wdata and we (`we = mi_mem_wr`); set `mo_bus_req=1`; clear the timeout counter; go to ACCESS.
- ACCESS:
  - Hold req, addr, wdata and we stable. `mo_stall=1`, `mo_valid=0`. Counter increments each cycle.
  - Edge with `mi_bus_ack=1`: drop req, capture `mi_bus_rdata` (loads), go to DONE.
  - Edge with counter == `BUS_TIMEOUT-1` and no ack: drop req, captured data = 16'hdd, set `mo_bus_err`, go to DONE.
- DONE:
  - `mo_stall=0`, `mo_valid=1`.
  - `mo_result` = captured data for loads, `mi_alu_result` for stores.
  - Other outputs are the EX/MEM inputs, which are still frozen.
  - Next edge: IDLE. Upstream advances on that same edge.
- `mi_mem_rd` and `mi_mem_wr` both high is illegal; the write takes priority.
- Bubble outputs (whenever `mo_valid=0`): instr 0, pc 0, result 16'hdd, wreg_addr `REG_INVALID`, reg_wrn 0.
- An ack received in IDLE or DONE is ignored.

## Timing
- Reset values:
  - state IDLE, `mo_bus_req=0`, `mo_bus_we=0`, addr 0, wdata 0, `mo_bus_err=0`, counter 0.
  - With IDLE and no bus-op, outputs follow the combinational rules above.
- Non-memory instruction: 0 added cycles.
- Bus access with ack in the first ACCESS cycle: the instruction occupies MEM for 3 cycles (IDLE, ACCESS, DONE); `mo_stall` is high for 2.
- Each extra wait cycle adds 1.
- Timeout: DONE is entered `BUS_TIMEOUT` cycles after entering ACCESS.
- Reset asserted mid-access: `mo_bus_req` and `mo_bus_we` drop asynchronously and state returns to IDLE. No partial result reaches `mem_wb`.
- `mo_bus_req` is purely registered and never glitches.

## Structure
- `defines.v`: `REG_INVALID`, `UART_DATA` (16'hBF00), `UART_STAT` (16'hBF01), the FSM state encodings, and the bubble result 16'hdd.
- Sub-module `mem_bus_ctrl`: FSM, timeout counter, bus output registers, read-data capture and `mo_bus_err`.
- Top level `mem_access`: bus-op decode, UART status mux, result/bubble muxing, and the stall/valid outputs.

## Test plan
- ALU instr, `mi_alu_result=16'h1234`, `wreg 3` → same cycle `mo_result=16'h1234`, `mo_valid=1`, `mo_stall=0`, no `mo_bus_req`.
- Load from 16'h8000, ack after 2 wait cycles with rdata 16'hBEEF → `mo_stall` high 4 cycles, then DONE `mo_result=16'hBEEF`, `mo_valid=1`.
- Store 16'h00AA to 16'h9000, immediate ack → `mo_bus_we=1`, addr 16'h9000, wdata 16'h00AA held until ack; 3-cycle occupancy.
- Read of 16'hBF01 with tbre=tsre=1, data_ready=0 → `mo_result=16'h0001`, 0 stall cycles, no bus request.
- `BUS_TIMEOUT=4`, never ack → DONE after 4 ACCESS cycles, `mo_result=16'hdd`, `mo_bus_err=1` and still 1 after 10 more instructions.
- Reset pulse in the 2nd ACCESS cycle → `mo_bus_req=0` immediately, state IDLE, bubble outputs, `mo_bus_err=0`.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants, FSM encoding and helpers for the MEM stage
//
// Purpose : constants and types used by mem_access and mem_bus_ctrl.
// Contents: REG_INVALID, UART_DATA/UART_STAT addresses, bubble result value,
//           bus FSM state encoding, UART status word helper.
package mem_access_pkg;

    localparam logic [3:0]  REG_INVALID   = 4'hF;
    localparam logic [15:0] UART_DATA     = 16'hBF00;
    // The status register sits directly above the data register.
    localparam logic [15:0] UART_STAT     = UART_DATA + 16'h0001;
    localparam logic [15:0] BUBBLE_RESULT = 16'h00DD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_e;

    // Status word: bit1 = receive data ready, bit0 = transmitter fully empty.
    function automatic logic [15:0] uart_status(input logic data_ready,
                                                input logic tbre,
                                                input logic tsre);
        return {14'b0, data_ready, tbre & tsre};
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data bus req/ack interface between MEM stage and memory
//
// Purpose : groups the shared data-bus signals.
// Ports   : mo_bus_req/mo_bus_we/mo_bus_addr/mo_bus_wdata driven by the master,
//           mi_bus_rdata/mi_bus_ack driven by the slave.
interface mem_access_if;

    logic        mo_bus_req;
    logic        mo_bus_we;
    logic [15:0] mo_bus_addr;
    logic [15:0] mo_bus_wdata;
    logic [15:0] mi_bus_rdata;
    logic        mi_bus_ack;

    modport master (
        output mo_bus_req, mo_bus_we, mo_bus_addr, mo_bus_wdata,
        input  mi_bus_rdata, mi_bus_ack
    );

    modport slave (
        input  mo_bus_req, mo_bus_we, mo_bus_addr, mo_bus_wdata,
        output mi_bus_rdata, mi_bus_ack
    );

endinterface

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - bus access FSM, timeout counter and bus output registers
//
// Purpose : runs one req/ack bus cycle per memory instruction.
// Ports   : mwi_clk/mwi_rst (async active-low) clock and reset;
//           op_req (bus-op present), op_we, op_addr, op_wdata from the stage;
//           bus (master modport); state (FSM state), cap_rdata (captured read
//           data or bubble value on timeout), bus_err (sticky timeout flag).
module mem_bus_ctrl
    import mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic          mwi_clk,
    input  logic          mwi_rst,
    input  logic          op_req,
    input  logic          op_we,
    input  logic [15:0]   op_addr,
    input  logic [15:0]   op_wdata,
    mem_access_if.master  bus,
    output bus_state_e    state,
    output logic [15:0]   cap_rdata,
    output logic          bus_err
);

    localparam logic [7:0] CNT_LAST = 8'(BUS_TIMEOUT - 1);

    bus_state_e  state_q,  state_d;
    logic        req_q,    req_d;
    logic        we_q,     we_d;
    logic [15:0] addr_q,   addr_d;
    logic [15:0] wdata_q,  wdata_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic [15:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    always_ff @(posedge mwi_clk or negedge mwi_rst) begin
        if (!mwi_rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            cnt_q   <= 8'h00;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (op_req) begin
                    req_d   = 1'b1;
                    we_d    = op_we;
                    addr_d  = op_addr;
                    wdata_d = op_wdata;
                    cnt_d   = 8'h00;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 8'h01;
                // An ack on the final allowed cycle still completes normally.
                if (bus.mi_bus_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    rdata_d = bus.mi_bus_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    rdata_d = BUBBLE_RESULT;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    assign bus.mo_bus_req   = req_q;
    assign bus.mo_bus_we    = we_q;
    assign bus.mo_bus_addr  = addr_q;
    assign bus.mo_bus_wdata = wdata_q;

    assign state     = state_q;
    assign cap_rdata = rdata_q;
    assign bus_err   = err_q;

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: pass-through, UART status, bus loads/stores
//
// Purpose : forwards ALU results, decodes the UART status read locally and
//           runs loads/stores on the data bus, stalling upstream meanwhile.
// Ports   : mwi_clk/mwi_rst (async active-low); mi_* EX/MEM fields and UART
//           status lines; bus (master modport); mo_* fields to mem_wb,
//           mo_valid (mem_wb enable), mo_stall (upstream freeze),
//           mo_bus_err (sticky bus timeout).
module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic          mwi_clk,
    input  logic          mwi_rst,
    input  logic [15:0]   mi_instr,
    input  logic [15:0]   mi_pc,
    input  logic [15:0]   mi_alu_result,
    input  logic [15:0]   mi_store_data,
    input  logic          mi_mem_rd,
    input  logic          mi_mem_wr,
    input  logic [3:0]    mi_wreg_addr,
    input  logic          mi_reg_wrn,
    input  logic          mi_uart_tbre,
    input  logic          mi_uart_tsre,
    input  logic          mi_uart_data_ready,
    mem_access_if.master  bus,
    output logic [15:0]   mo_instr,
    output logic [15:0]   mo_pc,
    output logic [15:0]   mo_result,
    output logic [3:0]    mo_wreg_addr,
    output logic          mo_reg_wrn,
    output logic          mo_valid,
    output logic          mo_stall,
    output logic          mo_bus_err
);

    bus_state_e  state;
    logic [15:0] cap_rdata;
    logic        is_load;
    logic        is_stat_rd;
    logic        bus_op;
    logic        valid;

    // A write wins when both strobes are set, so only a pure read of the
    // status address is served locally.
    always_comb begin
        is_load    = mi_mem_rd & ~mi_mem_wr;
        is_stat_rd = is_load & (mi_alu_result == UART_STAT);
        bus_op     = mi_mem_wr | (is_load & ~is_stat_rd);
    end

    mem_bus_ctrl #(
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) u_bus_ctrl (
        .mwi_clk   (mwi_clk),
        .mwi_rst   (mwi_rst),
        .op_req    (bus_op),
        .op_we     (mi_mem_wr),
        .op_addr   (mi_alu_result),
        .op_wdata  (mi_store_data),
        .bus       (bus),
        .state     (state),
        .cap_rdata (cap_rdata),
        .bus_err   (mo_bus_err)
    );

    always_comb begin
        valid        = (state == ST_DONE) | ((state == ST_IDLE) & ~bus_op);
        mo_valid     = valid;
        mo_stall     = ~valid;
        mo_instr     = 16'h0000;
        mo_pc        = 16'h0000;
        mo_result    = BUBBLE_RESULT;
        mo_wreg_addr = REG_INVALID;
        mo_reg_wrn   = 1'b0;
        if (valid) begin
            mo_instr     = mi_instr;
            mo_pc        = mi_pc;
            mo_wreg_addr = mi_wreg_addr;
            mo_reg_wrn   = mi_reg_wrn;
            // EX/MEM is still frozen in DONE, so is_load describes the
            // instruction whose access just finished.
            if (state == ST_DONE)
                mo_result = is_load ? cap_rdata : mi_alu_result;
            else if (is_stat_rd)
                mo_result = uart_status(mi_uart_data_ready, mi_uart_tbre, mi_uart_tsre);
            else
                mo_result = mi_alu_result;
        end
    end

endmodule
